// File: rtl/csr_req_arb.sv
// csr_req_arb: round-robin arbiter that shares one CSR/memory access path
// between NUM_REQ requesters. It decodes each winning addr_t into a target class
// and keeps a single transaction outstanding. Illegal addresses are answered locally
// with an error response.
// Optional feature: define CSR_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.

module csr_req_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*27-1:0]         i_req_addr,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic                          o_dn_valid,
  input  logic                          i_dn_ready,
  output logic [26:0]                   o_dn_addr,
  output logic                          o_dn_wr,
  output logic [DATA_WIDTH-1:0]         o_dn_wdata,
  output logic [1:0]                    o_dn_target,
  input  logic                          i_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         i_rsp_rdata,
  input  logic                          i_rsp_err,
  output logic [NUM_REQ-1:0]            o_up_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_up_rsp_rdata,
  output logic                          o_up_rsp_err,
  output logic                          o_spurious_rsp
);

  localparam int unsigned AW = 27;
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StSend, StWait, StResp, StErr} state_e;

  state_e                r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, r_owner;
  logic [AW-1:0]         r_addr;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_target;
  logic [NUM_REQ-1:0]    r_up_valid;
  logic [DATA_WIDTH-1:0] r_up_rdata;
  logic                  r_up_err;
  logic                  r_spur;

  logic                  w_gnt_any;
  logic [PW-1:0]         w_gnt_idx;
  logic [PW-1:0]         w_cand;
  logic                  w_accept;
  logic [AW-1:0]         w_sel_addr;
  logic                  w_sel_legal;
  logic [1:0]            w_sel_target;
  logic                  w_expired;

  // Round-robin search over requesters, starting at the pointer.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = PW'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_gnt_any && i_req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_accept   = (r_state == StIdle) && w_gnt_any;
  assign w_sel_addr = i_req_addr[w_gnt_idx*AW +: AW];

  // Target-class decode and legality check of the granted address.
  always_comb begin
    w_sel_legal  = 1'b1;
    w_sel_target = 2'd2;
    if (w_sel_addr[26]) begin
      if (w_sel_addr[25]) begin
        w_sel_target = 2'd0;
        w_sel_legal  = (w_sel_addr[18:15] != 4'd0) && (w_sel_addr[18:15] < 4'd13);
      end else begin
        w_sel_target = 2'd1;
      end
    end else if (w_sel_addr[25:23] == 3'd6) begin
      w_sel_target = 2'd3;
      w_sel_legal  = (w_sel_addr[19:18] != 2'd3);
    end else if (w_sel_addr[25:23] == 3'd3) begin
      w_sel_legal = 1'b0;
    end
  end

`ifdef CSR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;

  // Counts WAIT cycles; restarts on every entry into WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == StSend && i_dn_ready) begin
      r_wait_cnt <= '0;
    end else if (r_state == StWait) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_expired = (r_state == StWait) && (r_wait_cnt == CW'(TIMEOUT - 1));
`else
  assign w_expired = 1'b0;
`endif

  // Next-state logic and the combinational grant.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_any) begin
          o_req_ready[w_gnt_idx] = 1'b1;
          w_state_nxt = w_sel_legal ? StSend : StErr;
        end
      end
      StSend:        if (i_dn_ready) w_state_nxt = StWait;
      StWait:        if (i_rsp_valid || w_expired) w_state_nxt = StResp;
      StResp, StErr: w_state_nxt = StIdle;
      default:       w_state_nxt = StIdle;
    endcase
  end

  // State register, pointer and latched request fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner  <= w_gnt_idx;
        r_addr   <= w_sel_addr;
        r_wr     <= i_req_wr[w_gnt_idx];
        r_wdata  <= i_req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        r_target <= w_sel_target;
        r_ptr    <= (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  // Registered one-cycle upstream response and spurious-response pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_up_valid <= '0;
      r_up_rdata <= '0;
      r_up_err   <= 1'b0;
      r_spur     <= 1'b0;
    end else begin
      r_up_valid <= '0;
      r_up_rdata <= '0;
      r_up_err   <= 1'b0;
      r_spur     <= i_rsp_valid && (r_state != StWait);
      if (w_accept && !w_sel_legal) begin
        r_up_valid <= NUM_REQ'(1) << w_gnt_idx;
        r_up_err   <= 1'b1;
      end else if (r_state == StWait && i_rsp_valid) begin
        r_up_valid <= NUM_REQ'(1) << r_owner;
        r_up_rdata <= i_rsp_rdata;
        r_up_err   <= i_rsp_err;
      end else if (w_expired) begin
        r_up_valid <= NUM_REQ'(1) << r_owner;
        r_up_err   <= 1'b1;
      end
    end
  end

  assign o_dn_valid     = (r_state == StSend);
  assign o_dn_addr      = r_addr;
  assign o_dn_wr        = r_wr;
  assign o_dn_wdata     = r_wdata;
  assign o_dn_target    = r_target;
  assign o_up_rsp_valid = r_up_valid;
  assign o_up_rsp_rdata = r_up_rdata;
  assign o_up_rsp_err   = r_up_err;
  assign o_spurious_rsp = r_spur;

endmodule

// File: tb/tb_csr_req_arb.sv
// Self-checking bench for csr_req_arb: a transaction-level model checked every
// cycle plus directed scenarios with literal expectations.
// With CSR_ARB_TIMEOUT_EN defined, the timeout scenario runs with TIMEOUT = 16.

module tb_csr_req_arb;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [107:0] req_addr;
  logic [3:0]   req_wr;
  logic [127:0] req_wdata;
  logic         dn_valid;
  logic         dn_ready;
  logic [26:0]  dn_addr;
  logic         dn_wr;
  logic [31:0]  dn_wdata;
  logic [1:0]   dn_target;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   up_rsp_valid;
  logic [31:0]  up_rsp_rdata;
  logic         up_rsp_err;
  logic         spurious_rsp;

  int checks = 0;
  int failures = 0;

  csr_req_arb #(
    .NUM_REQ   (4),
    .DATA_WIDTH(32),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_wr      (req_wr),
    .i_req_wdata   (req_wdata),
    .o_dn_valid    (dn_valid),
    .i_dn_ready    (dn_ready),
    .o_dn_addr     (dn_addr),
    .o_dn_wr       (dn_wr),
    .o_dn_wdata    (dn_wdata),
    .o_dn_target   (dn_target),
    .i_rsp_valid   (rsp_valid),
    .i_rsp_rdata   (rsp_rdata),
    .i_rsp_err     (rsp_err),
    .o_up_rsp_valid(up_rsp_valid),
    .o_up_rsp_rdata(up_rsp_rdata),
    .o_up_rsp_err  (up_rsp_err),
    .o_spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First valid requester at or after p, or -1.
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[2'((p + k) % 4)]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Target class of an address, or -1 when the address is illegal.
  function automatic int classify(input logic [26:0] a);
    int zb, nb, rb;
    zb = int'(a[18:15]);
    nb = int'(a[25:23]);
    rb = int'(a[19:18]);
    if (a[26] && a[25]) return (zb >= 1 && zb <= 12) ? 0 : -1;
    if (a[26]) return 1;
    if (nb == 6) return (rb == 3) ? -1 : 3;
    if (nb == 3) return -1;
    return 2;
  endfunction

  // Transaction model: busy from accept until the cycle after the response.
  bit          m_init = 0;
  bit          m_busy, m_dn, m_wait;
  int          m_ptr, m_owner, m_tgt, m_wcnt;
  logic [26:0] m_addr;
  logic        m_wr;
  logic [31:0] m_wdata;
  logic [3:0]  e_up;
  logic [31:0] e_rdata;
  logic        e_err, e_spur;

  always @(posedge clk) begin : model
    int g;
    e_spur  = rsp_valid && !m_wait;
    e_up    = '0;
    e_rdata = '0;
    e_err   = 1'b0;
    if (rst) begin
      m_init = 1; m_busy = 0; m_dn = 0; m_wait = 0; m_ptr = 0; m_wcnt = 0;
      e_spur = 1'b0;
    end else if (!m_busy) begin
      g = rr_pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_owner = g;
        m_addr  = req_addr[g*27 +: 27];
        m_wr    = req_wr[g];
        m_wdata = req_wdata[g*32 +: 32];
        m_ptr   = (g + 1) % 4;
        m_tgt   = classify(m_addr);
        m_busy  = 1;
        if (m_tgt < 0) begin
          e_up  = 4'(1 << g);
          e_err = 1'b1;
        end else begin
          m_dn = 1;
        end
      end
    end else if (m_dn) begin
      if (dn_ready) begin
        m_dn = 0; m_wait = 1; m_wcnt = 0;
      end
    end else if (m_wait) begin
      m_wcnt++;
      if (rsp_valid) begin
        e_up = 4'(1 << m_owner); e_rdata = rsp_rdata; e_err = rsp_err; m_wait = 0;
      end
`ifdef CSR_ARB_TIMEOUT_EN
      else if (m_wcnt == TMO) begin
        e_up = 4'(1 << m_owner); e_err = 1'b1; m_wait = 0;
      end
`endif
    end else begin
      m_busy = 0;
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin : compare
    int g;
    logic [3:0] er;
    if (m_init && !rst) begin
      er = '0;
      if (!m_busy) begin
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) er = 4'(1 << g);
      end
      chk("m_req_ready", 64'(req_ready), 64'(er));
      chk("m_dn_valid", 64'(dn_valid), 64'(m_dn));
      if (m_dn) begin
        chk("m_dn_addr", 64'(dn_addr), 64'(m_addr));
        chk("m_dn_wr", 64'(dn_wr), 64'(m_wr));
        chk("m_dn_wdata", 64'(dn_wdata), 64'(m_wdata));
        chk("m_dn_target", 64'(dn_target), 64'(m_tgt));
      end
      chk("m_up_valid", 64'(up_rsp_valid), 64'(e_up));
      chk("m_up_rdata", 64'(up_rsp_rdata), 64'(e_rdata));
      chk("m_up_err", 64'(up_rsp_err), 64'(e_err));
      chk("m_spurious", 64'(spurious_rsp), 64'(e_spur));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [26:0] a, input logic w, input logic [31:0] d);
    req_addr[i*27 +: 27]  = a;
    req_wr[i]             = w;
    req_wdata[i*32 +: 32] = d;
  endtask

  // Waits (bounded) for a grant; returns just after the accepting edge.
  task automatic grant_wait(output int g);
    g = -1;
    for (int k = 0; k < 20 && g < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
      cyc();
    end
    if (g < 0) begin
      checks++;
      failures++;
      $display("FAIL grant_wait: got no grant expected a grant within 20 cycles");
    end
  endtask

  // From SEND: handshake downstream, respond, return in IDLE.
  task automatic complete(input logic [31:0] rd, input logic er);
    dn_ready = 1'b1; cyc(); dn_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = rd; rsp_err = er; cyc();
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    cyc();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 64'(req_ready), 64'(0));
    chk({nm, "_dn_valid"}, 64'(dn_valid), 64'(0));
    chk({nm, "_dn_fields"}, 64'({dn_addr, dn_wr, dn_target}), 64'(0));
    chk({nm, "_dn_wdata"}, 64'(dn_wdata), 64'(0));
    chk({nm, "_up"}, 64'({up_rsp_valid, up_rsp_err, spurious_rsp}), 64'(0));
    chk({nm, "_up_rdata"}, 64'(up_rsp_rdata), 64'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int g, n;
    req_valid = '0; req_addr = '0; req_wr = '0; req_wdata = '0;
    dn_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    cyc();

    // Fairness: all four held valid, grant order 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 4; i++) set_req(i, 27'h0800000 + 27'(i), 1'b0, 32'h0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      grant_wait(g);
      chk("fair_order", 64'(g), 64'(k % 4));
      complete(32'h100 + 32'(k), 1'b0);
    end
    req_valid = '0;

    // Single read to ZAP_CSR block 1 (bits 26 and 25 set).
    set_req(0, 27'h6008000, 1'b0, 32'h0);
    req_valid = 4'b0001;
    grant_wait(g);
    req_valid = '0;
    chk("read_grant", 64'(g), 64'(0));
    @(negedge clk);
    chk("read_dn_valid", 64'(dn_valid), 64'(1));
    chk("read_dn_target", 64'(dn_target), 64'(0));
    dn_ready = 1'b1; cyc(); dn_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 32'hCAFE; cyc(); rsp_valid = 1'b0; rsp_rdata = '0;
    @(negedge clk);
    chk("read_up_valid", 64'(up_rsp_valid), 64'(4'b0001));
    chk("read_up_rdata", 64'(up_rsp_rdata), 64'(32'hCAFE));
    cyc();

    // 0x4008000 has bit 25 clear, so it decodes as ZAP_MEM.
    set_req(0, 27'h4008000, 1'b1, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    grant_wait(g);
    req_valid = '0;
    @(negedge clk);
    chk("zapmem_target", 64'(dn_target), 64'(1));
    chk("zapmem_wdata", 64'(dn_wdata), 64'(32'hDEAD_BEEF));
    complete(32'h0, 1'b0);

    // Illegal non_zap_block_id 3 from requester 2.
    set_req(2, 27'h1800000, 1'b0, 32'h0);
    req_valid = 4'b0100;
    grant_wait(g);
    req_valid = '0;
    @(negedge clk);
    chk("illegal_up_valid", 64'(up_rsp_valid), 64'(4'b0100));
    chk("illegal_err", 64'(up_rsp_err), 64'(1));
    chk("illegal_no_dn", 64'(dn_valid), 64'(0));
    cyc();

    // Rack decode: rack_block_id 3 is illegal, 1 is RACK.
    set_req(1, 27'h30C0000, 1'b0, 32'h0);
    req_valid = 4'b0010;
    grant_wait(g);
    req_valid = '0;
    @(negedge clk);
    chk("rack3_up", 64'({up_rsp_valid, up_rsp_err}), 64'({4'b0010, 1'b1}));
    cyc();
    set_req(1, 27'h3040000, 1'b0, 32'h0);
    req_valid = 4'b0010;
    grant_wait(g);
    req_valid = '0;
    @(negedge clk);
    chk("rack1_target", 64'(dn_target), 64'(3));
    complete(32'h7, 1'b0);

    // ZAP_CSR block 15 is illegal.
    set_req(0, 27'h6078000, 1'b0, 32'h0);
    req_valid = 4'b0001;
    grant_wait(g);
    req_valid = '0;
    @(negedge clk);
    chk("zapblk15_err", 64'({up_rsp_valid, up_rsp_err}), 64'({4'b0001, 1'b1}));
    cyc();

    // rsp_valid together with dn_ready in SEND is spurious.
    set_req(3, 27'h0800000, 1'b0, 32'h0);
    req_valid = 4'b1000;
    grant_wait(g);
    req_valid = '0;
    dn_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hBAD; cyc();
    dn_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    @(negedge clk);
    chk("send_spur", 64'({spurious_rsp, up_rsp_valid}), 64'({1'b1, 4'b0000}));
    rsp_valid = 1'b1; rsp_rdata = 32'h55; rsp_err = 1'b1; cyc();
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    @(negedge clk);
    chk("send_spur_rsp", 64'({up_rsp_valid, up_rsp_err}), 64'({4'b1000, 1'b1}));
    cyc();

    // Spurious response while idle.
    rsp_valid = 1'b1; cyc(); rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_spur", 64'(spurious_rsp), 64'(1));
    cyc();

    // Backpressure: dn_* stable for 5 cycles; a requester drops before grant.
    set_req(1, 27'h0812345, 1'b1, 32'h1234_5678);
    req_valid = 4'b0010;
    grant_wait(g);
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_dn", 64'({dn_valid, dn_wr, dn_addr}), 64'({1'b1, 1'b1, 27'h0812345}));
      chk("bp_wdata", 64'(dn_wdata), 64'(32'h1234_5678));
      req_valid = (k == 2) ? 4'b0001 : 4'b0000;
      cyc();
    end
    req_valid = '0;
    dn_ready = 1'b1; cyc(); dn_ready = 1'b0;

    // Reset in WAIT drops the transaction and the pointer.
    rst = 1'b1; cyc(); rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_wait");
    req_valid = 4'b1111;
    #1;
    chk("rst_ptr", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    cyc();

    // Unanswered WAIT.
    set_req(0, 27'h0800000, 1'b0, 32'h0);
    req_valid = 4'b0001;
    grant_wait(g);
    req_valid = '0;
    dn_ready = 1'b1; cyc(); dn_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (up_rsp_valid != 4'b0000) break;
      n++;
      cyc();
    end
`ifdef CSR_ARB_TIMEOUT_EN
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_err", 64'({up_rsp_valid, up_rsp_err}), 64'({4'b0001, 1'b1}));
    cyc();
    rsp_valid = 1'b1; cyc(); rsp_valid = 1'b0;
    @(negedge clk);
    chk("tmo_late_spur", 64'(spurious_rsp), 64'(1));
    cyc();
`else
    chk("wait_forever", 64'(n), 64'(40));
    rsp_valid = 1'b1; rsp_rdata = 32'hABCD; cyc(); rsp_valid = 1'b0; rsp_rdata = '0;
    @(negedge clk);
    chk("wait_late_rsp", 64'({up_rsp_valid, up_rsp_rdata}), 64'({4'b0001, 32'hABCD}));
    cyc();
`endif

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
